mmu_sequencer: RTL and testbench
================================

# mmu_sequencer

Controller that sequences one 2x2 systolic-array matrix multiply. It collects 4 weight bytes and 4 input bytes from the host into the operand memory, then drives the feeder's `en` and `compute_cycles` through the fixed 6-cycle schedule. It tags the four returning 8-bit results as they leave the feeder and signals completion. It sits between the host byte interface and `mmu_feeder`/operand memory.

## Interface
- Parameters: none (constants live in the package).
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load_valid` in 1: host byte present on `load_data`.
- `load_data` in 8: operand byte.
- `load_ready` out 1: sequencer accepts a byte this cycle.
- `start` in 1: request compute; sampled only in state FULL.
- `mem_we` out 1: operand memory write strobe.
- `mem_addr` out 3: bit2 = 0 weights / 1 inputs; bits[1:0] = element index.
- `mem_wdata` out 8: write data.
- `feeder_en` out 1: drives feeder `en`.
- `compute_cycles` out 3: drives feeder `compute_cycles`.
- `feeder_done` in 1: feeder `done`.
- `out_valid` out 1: feeder `host_outdata` holds a result this cycle.
- `out_index` out 2: result element (0..3) of the current `out_valid`.
- `busy` out 1: high in RUN and DRAIN.
- `mmu_done` out 1: one-cycle completion pulse.

## Operation
- States: LOAD, FULL, RUN, DRAIN. Reset state is LOAD.
- Reset values:
  - `byte_cnt`=0; `feeder_en`, `compute_cycles`, `out_valid`, `out_index`, `busy`, `mmu_done` all 0.
  - `load_ready`=1, decoded from state LOAD.
- LOAD:
  - `load_ready`=1.
  - `mem_we` = `load_valid` (combinational); `mem_addr`=`byte_cnt`; `mem_wdata`=`load_data`.
  - Byte order: weights[0..3], then inputs[0..3].
  - Each accepted byte increments `byte_cnt` (3 bits).
  - The 8th byte (`byte_cnt`=7) wraps the count to 0 and moves to FULL.
- FULL: `load_ready`=0. `start` moves to RUN with `compute_cycles`=0 and `feeder_en`=1 (registered).
- RUN:
  - `compute_cycles` increments 0→5 on successive cycles.
  - After the cycle showing 5, go to DRAIN: `feeder_en`=0, `compute_cycles`=0.
- DRAIN: exactly one cycle, then LOAD.
- Result tagging:
  - `out_valid` <= `feeder_done` registered, qualified by RUN, to match the feeder's registered `host_outdata`.
  - `out_index` = 0 on the first `out_valid`, incrementing per valid.
  - `out_index` clears when entering LOAD.
- `mmu_done` pulses in the DRAIN cycle, coincident with `out_valid`/`out_index`=3.
- Ignored inputs (no state change):
  - `start` outside FULL.
  - `load_valid` outside LOAD; `mem_we` stays 0.
- Simultaneous `load_valid` and `start` in LOAD: the byte is taken, `start` is ignored.
- Reset mid-RUN: next cycle `feeder_en`=0, which makes the feeder assert `clear`. The partial result is lost, `byte_cnt`=0, and operands must be reloaded.

## Timing
- Start sampled at edge T:
  - `feeder_en`=1, `compute_cycles`=0 in cycle T+1; `compute_cycles`=5 in T+6.
  - `feeder_done` is high T+3..T+6.
  - `out_valid` is high T+4..T+7 with `out_index` 0,1,2,3.
  - `mmu_done` and DRAIN in T+7; LOAD and `load_ready`=1 in T+8.
- `busy` is high T+1..T+7.
- Back-to-back jobs:
  - Minimum spacing is 8 load cycles plus 1 FULL cycle plus 7 busy cycles.
  - Host may stream bytes from T+8.
- Write latency: 0 (`mem_we` is combinational in the acceptance cycle).

## Configuration
- `MMU_SEQ_AUTOSTART_EN` defined:
  - FULL is skipped. Acceptance of the 8th byte at edge T acts as `start` sampled at T, so `feeder_en`=1 at T+1.
  - `start` is ignored entirely.
- Not defined: the sequencer waits in FULL for `start` as described above.

## Structure
- `mmu_seq_pkg` holds:
  - state enum (LOAD, FULL, RUN, DRAIN);
  - `NUM_OPERAND_BYTES`=8;
  - `LAST_COMPUTE_CYCLE`=3'd5;
  - `ADDR_INPUT_BIT`=2.
- One sub-module, `mmu_seq_loader`: owns `byte_cnt`, `load_ready`, the `mem_*` decode and the `last_byte` strobe.
- The top holds the FSM, the cycle counter and result tagging.

## Test plan
- Reset, then load bytes 1..8 → `mem_addr` 0..7 with matching `mem_wdata`, FULL reached; `start` → `compute_cycles` 0,1,2,3,4,5 on consecutive cycles with `feeder_en`=1.
- Weights {1,2,3,4}, inputs {5,6,7,8}, then `start` → `out_valid` on 4 consecutive cycles, `out_index` 0..3. `host_outdata` must equal the low bytes of C=A×B; verify against the reference product. `mmu_done` coincides with index 3.
- `start` pulsed after only 5 bytes loaded → no RUN. Then 3 more bytes plus `start` → normal run.
- `load_valid` held during RUN/DRAIN → `mem_we`=0, `byte_cnt` unchanged; the first accepted byte after DRAIN goes to `mem_addr`=0.
- `rst` asserted at `compute_cycles`=3 → next cycle `feeder_en`=0, `out_valid`=0, `load_ready`=1; reload plus `start` → correct results.
- With `MMU_SEQ_AUTOSTART_EN`: 8th byte at edge T → `feeder_en`=1 at T+1, `mmu_done` at T+7, `start` ignored.

Source files
------------

// File: rtl/mmu_seq_pkg.sv
// mmu_seq_pkg
// Shared definitions for the 2x2 systolic-array matrix-multiply sequencer:
// the controller state encoding, the operand byte count, the last feeder
// compute cycle and the address bit that selects the input bank.
package mmu_seq_pkg;

    // Controller states. LOAD collects operands, FULL waits for start,
    // RUN walks the feeder schedule and DRAIN releases the last result.
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FULL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } mmu_state_e;

    // Four weight bytes followed by four input bytes.
    localparam int NUM_OPERAND_BYTES = 8;

    // Index of the last operand byte. The byte counter wraps from this
    // value back to zero.
    localparam logic [2:0] LAST_BYTE_IDX = 3'(NUM_OPERAND_BYTES - 1);

    // The feeder schedule runs compute_cycles 0..5.
    localparam logic [2:0] LAST_COMPUTE_CYCLE = 3'd5;

    // mem_addr bit that separates weights (0) from inputs (1).
    localparam int ADDR_INPUT_BIT = 2;

endpackage

// File: rtl/mmu_seq_loader.sv
// mmu_seq_loader
// Operand loader for the matrix-multiply sequencer. It owns the byte
// counter, accepts host bytes while the controller is in LOAD and turns
// each accepted byte into a zero-latency operand memory write.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   loadEn       - controller is in LOAD
//   load_valid   - host byte present on load_data
//   load_data    - operand byte
//   load_ready   - a byte is accepted this cycle if load_valid is high
//   mem_we       - operand memory write strobe
//   mem_addr     - {bank, element}; bank 0 = weights, 1 = inputs
//   mem_wdata    - operand memory write data
//   last_byte    - the eighth operand byte is being accepted this cycle
module mmu_seq_loader
    import mmu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       loadEn,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    output logic       mem_we,
    output logic [2:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       last_byte
);

    logic [2:0] byteCnt_q;
    logic [2:0] byteCnt_d;
    logic       accept;

    // A byte is taken only while the controller is loading. The 3-bit
    // counter wraps naturally after the eighth byte, so the next job
    // starts again at weight element 0.
    always_comb begin
        accept    = loadEn & load_valid;
        byteCnt_d = byteCnt_q;
        if (accept) begin
            byteCnt_d = byteCnt_q + 3'd1;
        end
    end

    // Byte counter register; reset discards any partially loaded job.
    always_ff @(posedge clk) begin
        if (rst) begin
            byteCnt_q <= 3'd0;
        end else begin
            byteCnt_q <= byteCnt_d;
        end
    end

    // The byte count doubles as the memory address: the upper bit picks
    // the weight or input bank and the low bits pick the element.
    assign load_ready = loadEn;
    assign mem_we     = accept;
    assign mem_addr   = {byteCnt_q[ADDR_INPUT_BIT], byteCnt_q[1:0]};
    assign mem_wdata  = load_data;
    assign last_byte  = accept && (byteCnt_q == LAST_BYTE_IDX);

endmodule

// File: rtl/mmu_sequencer.sv
// mmu_sequencer
// Sequences one 2x2 systolic-array matrix multiply: loads 4 weight and 4
// input bytes into operand memory, drives the feeder through its 6-cycle
// compute schedule, tags the four returning results and pulses mmu_done.
// Optional feature macro: MMU_SEQ_AUTOSTART_EN - when defined the job
// starts as soon as the eighth byte is accepted and start is ignored.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   load_valid/data - host operand byte stream; load_ready while loading
//   start           - compute request, honoured only in FULL
//   mem_we/addr/wdata - operand memory write port
//   feeder_en       - feeder enable (registered)
//   compute_cycles  - feeder schedule step 0..5 (registered)
//   feeder_done     - feeder has a result this cycle
//   out_valid       - feeder host_outdata holds a result this cycle
//   out_index       - element index 0..3 of the current result
//   busy            - job in RUN or DRAIN
//   mmu_done        - one-cycle completion pulse with the last result
module mmu_sequencer
    import mmu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    input  logic       start,
    output logic       mem_we,
    output logic [2:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       feeder_en,
    output logic [2:0] compute_cycles,
    input  logic       feeder_done,
    output logic       out_valid,
    output logic [1:0] out_index,
    output logic       busy,
    output logic       mmu_done
);

    mmu_state_e state_q;
    mmu_state_e state_d;
    logic       feederEn_q;
    logic       feederEn_d;
    logic [2:0] computeCycles_q;
    logic [2:0] computeCycles_d;
    logic       outValid_q;
    logic       outValid_d;
    logic [1:0] outIndex_q;
    logic [1:0] outIndex_d;
    logic       lastByte;

`ifdef MMU_SEQ_AUTOSTART_EN
    // start has no effect in this build.
    logic unusedStart;
    assign unusedStart = start;
`endif

    mmu_seq_loader u_loader (
        .clk        (clk),
        .rst        (rst),
        .loadEn     (state_q == LOAD),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .last_byte  (lastByte)
    );

    // Next-state logic. feeder_en and compute_cycles are computed for the
    // cycle being entered, so they line up with the state register and
    // drop back to zero the moment the schedule ends.
    always_comb begin
        state_d         = state_q;
        feederEn_d      = 1'b0;
        computeCycles_d = 3'd0;
        case (state_q)
            LOAD: begin
                if (lastByte) begin
`ifdef MMU_SEQ_AUTOSTART_EN
                    state_d    = RUN;
                    feederEn_d = 1'b1;
`else
                    state_d    = FULL;
`endif
                end
            end
            FULL: begin
`ifndef MMU_SEQ_AUTOSTART_EN
                if (start) begin
                    state_d    = RUN;
                    feederEn_d = 1'b1;
                end
`endif
            end
            RUN: begin
                if (computeCycles_q == LAST_COMPUTE_CYCLE) begin
                    state_d = DRAIN;
                end else begin
                    feederEn_d      = 1'b1;
                    computeCycles_d = computeCycles_q + 3'd1;
                end
            end
            DRAIN: begin
                state_d = LOAD;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Result tagging. The feeder registers host_outdata, so its done flag
    // is delayed by one cycle here to mark when the data is really there.
    // The index counts results and is cleared on the way back to LOAD.
    always_comb begin
        outValid_d = feeder_done && (state_q == RUN);
        outIndex_d = outIndex_q;
        if (state_d == LOAD) begin
            outIndex_d = 2'd0;
        end else if (outValid_q) begin
            outIndex_d = outIndex_q + 2'd1;
        end
    end

    // State and output registers. A reset mid-job drops feeder_en, which
    // makes the feeder clear its partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= LOAD;
            feederEn_q      <= 1'b0;
            computeCycles_q <= 3'd0;
            outValid_q      <= 1'b0;
            outIndex_q      <= 2'd0;
        end else begin
            state_q         <= state_d;
            feederEn_q      <= feederEn_d;
            computeCycles_q <= computeCycles_d;
            outValid_q      <= outValid_d;
            outIndex_q      <= outIndex_d;
        end
    end

    assign feeder_en      = feederEn_q;
    assign compute_cycles = computeCycles_q;
    assign out_valid      = outValid_q;
    assign out_index      = outIndex_q;
    assign busy           = (state_q == RUN) || (state_q == DRAIN);
    assign mmu_done       = (state_q == DRAIN);

endmodule

// File: tb/tb_mmu_sequencer.sv
// tb_mmu_sequencer
// Self-checking bench for mmu_sequencer. A small feeder stub produces
// feeder_done from the schedule and returns results computed from the
// operand memory as written by the DUT. The reference model tracks the
// job as "bytes loaded" and "cycles since start" and derives every
// expected output from the documented timeline.
// Honours MMU_SEQ_AUTOSTART_EN when defined.
`timescale 1ns/1ps
module tb_mmu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       loadValid;
    logic [7:0] loadData;
    logic       loadReady;
    logic       start;
    logic       memWe;
    logic [2:0] memAddr;
    logic [7:0] memWdata;
    logic       feederEn;
    logic [2:0] computeCycles;
    logic       feederDone;
    logic       outValid;
    logic [1:0] outIndex;
    logic       busy;
    logic       mmuDone;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int         mBytes;
    bit         mFull;
    int         mK;
    logic [7:0] sentB  [8];
    logic [7:0] capMem [8];
    logic [7:0] refC   [4];
    logic [7:0] obsRes [4];

    mmu_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .load_valid     (loadValid),
        .load_data      (loadData),
        .load_ready     (loadReady),
        .start          (start),
        .mem_we         (memWe),
        .mem_addr       (memAddr),
        .mem_wdata      (memWdata),
        .feeder_en      (feederEn),
        .compute_cycles (computeCycles),
        .feeder_done    (feederDone),
        .out_valid      (outValid),
        .out_index      (outIndex),
        .busy           (busy),
        .mmu_done       (mmuDone)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Feeder stub: results leave the array during schedule steps 2..5
    assign feederDone = feederEn && (computeCycles >= 3'd2);

    // Count one comparison and report it when it disagrees
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Low byte of C[idx] where C = X * W, X = inputs (mem 4..7) and
    // W = weights (mem 0..3), both 2x2 row-major
    function automatic logic [7:0] prod(input logic [7:0] m [8], input int idx);
        int i;
        int j;
        int s;
        i = idx / 2;
        j = idx % 2;
        s = int'(m[4 + 2*i]) * int'(m[j]) + int'(m[5 + 2*i]) * int'(m[2 + j]);
        return 8'(s);
    endfunction

    // Compare every output of the current cycle with the model
    task automatic checkCycle();
        bit         expReady;
        bit         expEn;
        bit         expValid;
        logic [7:0] res;
        expReady = (mK == 0) && !mFull;
        expEn    = (mK >= 1) && (mK <= 6);
        expValid = (mK >= 4);
        checkOutput("load_ready", loadReady, expReady);
        checkOutput("mem_we", memWe, expReady & loadValid);
        if (expReady && loadValid) begin
            checkOutput("mem_addr", memAddr, mBytes);
            checkOutput("mem_wdata", memWdata, loadData);
        end
        checkOutput("feeder_en", feederEn, expEn);
        checkOutput("compute_cycles", computeCycles, expEn ? mK - 1 : 0);
        checkOutput("busy", busy, mK >= 1);
        checkOutput("out_valid", outValid, expValid);
        checkOutput("out_index", outIndex, expValid ? mK - 4 : 0);
        checkOutput("mmu_done", mmuDone, mK == 7);
        if (expValid && outValid === 1'b1) begin
            res = prod(capMem, int'(outIndex));
            checkOutput("result", res, refC[mK - 4]);
            obsRes[mK - 4] = res;
        end
        if (memWe === 1'b1) begin
            capMem[memAddr] = memWdata;
        end
    endtask

    // Advance the model across one rising edge
    task automatic modelEdge();
        if (rst) begin
            mBytes = 0;
            mFull  = 0;
            mK     = 0;
        end else if (mK != 0) begin
            mK = (mK == 7) ? 0 : mK + 1;
        end else if (mFull) begin
            if (start) begin
                mFull = 0;
                mK    = 1;
            end
        end else if (loadValid) begin
            sentB[mBytes] = loadData;
            mBytes++;
            if (mBytes == 8) begin
                mBytes = 0;
                for (int k = 0; k < 4; k++) refC[k] = prod(sentB, k);
`ifdef MMU_SEQ_AUTOSTART_EN
                mK = 1;
`else
                mFull = 1;
`endif
            end
        end
    endtask

    // Drive one cycle of inputs, check at the falling edge, follow the edge
    task automatic applyStimulus(input logic r, input logic lv,
                                 input logic [7:0] ld, input logic st);
        rst       = r;
        loadValid = lv;
        loadData  = ld;
        start     = st;
        @(negedge clk);
        checkCycle();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic loadBytes(input int first, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 8'(first + i), 1'b0);
    endtask

    initial begin
        logic [7:0] expC [4];
        expC[0] = 8'd23;
        expC[1] = 8'd34;
        expC[2] = 8'd31;
        expC[3] = 8'd46;
        for (int k = 0; k < 8; k++) begin
            sentB[k]  = 8'd0;
            capMem[k] = 8'd0;
        end
        for (int k = 0; k < 4; k++) begin
            refC[k]   = 8'd0;
            obsRes[k] = 8'd0;
        end
        mBytes = 0;
        mFull  = 0;
        mK     = 0;

        // Reset
        rst       = 1'b1;
        loadValid = 1'b0;
        loadData  = 8'd0;
        start     = 1'b0;
        @(posedge clk);
        modelEdge();
        #1;
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        idle(1);

        // Weights 1..4, inputs 5..8, then start and watch the full schedule
        loadBytes(1, 8);
        idle(2);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
        idle(9);
        for (int k = 0; k < 4; k++) checkOutput("directed_C", obsRes[k], expC[k]);

        // start after only five bytes, then the remaining three plus start
        loadBytes(9, 5);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
        idle(2);
        loadBytes(14, 3);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
        idle(9);

        // load_valid held through RUN and DRAIN, then bytes stream again
        loadBytes(20, 8);
        applyStimulus(1'b0, 1'b1, 8'd99, 1'b1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 8'(40 + i), 1'b0);

        // Reset while compute_cycles shows 3, then reload and rerun
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        loadBytes(60, 8);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
        idle(3);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        idle(1);
        loadBytes(70, 8);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
        idle(9);

        // Randomized traffic, including rare resets
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 99) == 0),
                          1'($urandom_range(0, 1)),
                          8'($urandom),
                          ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
